regfile_write_arbiter: RTL and testbench

Sequencer and arbiter for the write port of the 16-entry x 4-bit register file. After reset, or on request, it sweeps every entry to zero, one entry per cycle. Otherwise it shares the single write port between two requesters using round-robin arbitration. Its outputs drive the register file's write_enable, rw and busw inputs directly; the register file writes on posedge clk.

---
 rtl/regfile_write_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Write-port sequencer for the register file. It clears every
//               entry one per cycle, then arbitrates two requesters round-robin.
// Revision    : 1.0
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        gnt,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_last_gnt;

  logic [1:0]        w_gnt;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_busy;

  // Outputs are combinational so a grant and its write share one posedge.
  always_comb begin
    w_gnt     = 2'b00;
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = '0;
    w_busy    = 1'b1;
    if (rst) begin
      if (r_state == ST_CLEAR) begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_clr_ptr;
      end else begin
        w_busy = 1'b0;
        // A clear request outranks any pending write this cycle.
        if (!clear_req) begin
          case (req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_last_gnt ? 2'b01 : 2'b10;
            default: w_gnt = 2'b00;
          endcase
          w_wr_en = |w_gnt;
          if (w_gnt[0]) begin
            w_wr_addr = addr0;
            w_wr_data = data0;
          end else if (w_gnt[1]) begin
            w_wr_addr = addr1;
            w_wr_data = data1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      r_last_gnt <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_ptr == c_last_ptr) begin
            r_clr_ptr <= '0;
            r_state   <= ST_RUN;
          end else begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
          end
        end
        default: begin
          if (clear_req) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
          end else if (w_gnt[0]) begin
            r_last_gnt <= 1'b0;
          end else if (w_gnt[1]) begin
            r_last_gnt <= 1'b1;
          end
        end
      endcase
    end
  end

  assign gnt     = w_gnt;
  assign wr_en   = w_wr_en;
  assign wr_addr = w_wr_addr;
  assign wr_data = w_wr_data;
  assign busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Table-driven self-checking bench with a small register file
//               model and an expected-value queue.
// Revision    : 1.0
// ============================================================================
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear_req = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] addr0 = '0, data0 = '0, addr1 = '0, data1 = '0;
  logic [1:0] gnt;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       busy;

  regfile_write_arbiter #(.DATA_W(4), .ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .req(req),
    .addr0(addr0), .data0(data0), .addr1(addr1), .data1(data1),
    .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file the arbiter feeds: writes on posedge.
  logic [3:0] mem [16];
  always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

  typedef struct {
    logic       rst, clr;
    logic [1:0] req;
    logic [3:0] a0, d0, a1, d1;
    logic [1:0] gnt;
    logic       we;
    logic [3:0] wa, wd;
    logic       busy;
    logic       mchk;
    logic [3:0] maddr, mval;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   vec_id = 0;

  function automatic vec_t mk(input logic r, input logic c, input logic [1:0] rq,
                              input logic [3:0] a0, input logic [3:0] d0,
                              input logic [3:0] a1, input logic [3:0] d1,
                              input logic [1:0] g, input logic we,
                              input logic [3:0] wa, input logic [3:0] wd,
                              input logic b);
    vec_t t;
    t.rst = r; t.clr = c; t.req = rq;
    t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
    t.gnt = g; t.we = we; t.wa = wa; t.wd = wd; t.busy = b;
    t.mchk = 1'b0; t.maddr = '0; t.mval = '0;
    return t;
  endfunction

  function automatic vec_t with_mem(input vec_t t, input logic [3:0] a, input logic [3:0] v);
    vec_t u;
    u = t;
    u.mchk = 1'b1; u.maddr = a; u.mval = v;
    return u;
  endfunction

  task automatic check_out();
    vec_t e;
    e = exp_q.pop_front();
    n_total++;
    if ({gnt, wr_en, wr_addr, wr_data, busy} === {e.gnt, e.we, e.wa, e.wd, e.busy})
      n_pass++;
    else
      $display("FAIL vec%0d: got gnt=%b wr_en=%b wr_addr=%0d wr_data=%h busy=%b, want gnt=%b wr_en=%b wr_addr=%0d wr_data=%h busy=%b",
               vec_id, gnt, wr_en, wr_addr, wr_data, busy, e.gnt, e.we, e.wa, e.wd, e.busy);
    if (e.mchk) begin
      n_total++;
      if (mem[e.maddr] === e.mval) n_pass++;
      else $display("FAIL vec%0d_mem[%0d]: got %h, want %h", vec_id, e.maddr, mem[e.maddr], e.mval);
    end
    vec_id++;
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; clear_req = t.clr; req = t.req;
    addr0 = t.a0; data0 = t.d0; addr1 = t.a1; data1 = t.d1;
  endtask

  task automatic apply(input vec_t t);
    drive(t);
    exp_q.push_back(t);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset, then full sweep, then an idle RUN cycle.
    repeat (2) tbl.push_back(mk(0, 0, 2'b11, 1, 5, 2, 6, 2'b00, 0, 0, 0, 1));
    for (int i = 0; i < 16; i++) tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 4'(i), 0, 1));
    tbl.push_back(with_mem(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), 4'd15, 4'h0));
    // Contention: requester 0 wins first after reset, then alternation.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 0, 2'b11, 0, 4'hF, 2, 4'h3,
                       (i % 2) ? 2'b10 : 2'b01, 1,
                       (i % 2) ? 4'd2 : 4'd0, (i % 2) ? 4'h3 : 4'hF, 0));
    tbl.push_back(mk(1, 0, 2'b01, 4, 4'hA, 2, 4'h3, 2'b01, 1, 4, 4'hA, 0));
    tbl.push_back(with_mem(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), 4'd4, 4'hA));
    // clear_req beats a pending request, then a sweep with a late request and a
    // second clear pulse that must not extend it.
    tbl.push_back(mk(1, 1, 2'b01, 4, 4'hA, 0, 0, 2'b00, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, (i == 8), (i >= 2) ? 2'b10 : 2'b00, 4, 4'hA, 9, 4'h6,
                       2'b00, 1, 4'(i), 0, 1));
    tbl.push_back(with_mem(mk(1, 0, 2'b10, 4, 4'hA, 9, 4'h6, 2'b10, 1, 9, 4'h6, 0), 4'd4, 4'h0));
    // Same address from both requesters: last_gnt=1 so requester 0 goes first.
    tbl.push_back(mk(1, 0, 2'b11, 5, 4'h1, 5, 4'h2, 2'b01, 1, 5, 4'h1, 0));
    tbl.push_back(mk(1, 0, 2'b11, 5, 4'h1, 5, 4'h2, 2'b10, 1, 5, 4'h2, 0));
    tbl.push_back(with_mem(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), 4'd5, 4'h2));
    tbl.push_back(mk(1, 1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);

    // Reset mid-sweep: wait (bounded) for wr_addr=7, then assert reset.
    drive(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    k = 0;
    forever begin
      @(negedge clk);
      if ((wr_addr == 4'd7 && busy) || k > 32) break;
      k++;
      @(posedge clk);
      #1;
    end
    n_total++;
    if (k == 7) n_pass++;
    else $display("FAIL sweep_to_addr7: got %0d cycles, want 7", k);
    rst = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    check_out();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) apply(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 4'(i), 0, 1));
    apply(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
